pid_sample_sched: RTL and testbench

Sample-rate scheduler and coefficient manager for the fan PID controller. Issues a single-cycle PID enable strobe at a programmable sample period and latches the ADC sample that the PID core processes. Holds the five PID coefficients in a double-buffered register bank, so software updates land atomically on a sample boundary. Flags sample ticks lost because the previous PID evaluation or ADC acquisition was still running.

---
 rtl/pid_sample_sched.sv | 165 ++++++++++++++++
 tb/tb_pid_sample_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_sample_sched.sv
// pid_sample_sched: sample-rate scheduler and double-buffered coefficient bank
// for the fan PID controller. A free-running period counter produces sample
// ticks. The FSM turns each accepted tick into one ADC capture and a
// single-cycle PID start strobe. Ticks that arrive while a capture or
// evaluation is still in flight are dropped and flagged. Software writes go to
// a shadow bank. A commit copies the whole shadow bank to the active bank at
// a sample boundary, so the PID core never sees a partial update.
module pid_sample_sched #(
  parameter int ADC_BITWIDTH = 8,
  parameter int REG_BITWIDTH = 32,
  parameter int DIV_BITWIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [DIV_BITWIDTH-1:0] sample_div_i,
  input  logic [ADC_BITWIDTH-1:0] ADC_value_i,
  input  logic                    ADC_valid_i,
  input  logic                    pid_busy_i,
  input  logic                    coeff_wr_i,
  input  logic [2:0]              coeff_addr_i,
  input  logic [REG_BITWIDTH-1:0] coeff_data_i,
  input  logic                    commit_i,
  input  logic                    clear_overrun_i,
  output logic                    clk_en_PID_o,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic [REG_BITWIDTH-1:0] b0_reg_o,
  output logic [REG_BITWIDTH-1:0] b1_reg_o,
  output logic [REG_BITWIDTH-1:0] b2_reg_o,
  output logic [REG_BITWIDTH-1:0] a0_reg_o,
  output logic [REG_BITWIDTH-1:0] a1_reg_o,
  output logic                    overrun_o,
  output logic                    commit_pending_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_ACQ   = 3'd2;
  localparam logic [2:0] ST_FIRE  = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;

  localparam int NUM_COEFF = 5;

  logic [2:0]              state_q, state_d;
  logic [DIV_BITWIDTH-1:0] cnt_q, cnt_d;
  logic                    clk_en_q;
  logic [ADC_BITWIDTH-1:0] adc_q;
  logic                    overrun_q, overrun_d;
  logic                    pending_q, pending_d;
  logic [REG_BITWIDTH-1:0] shadow_q [NUM_COEFF];
  logic [REG_BITWIDTH-1:0] active_q [NUM_COEFF];

  logic tick;
  logic capture;
  logic busy_state;
  logic copy;

  // Sample tick: the counter reaches zero while the scheduler runs.
  assign tick = enable_i && (cnt_q == '0);

  // The ADC sample is taken on the ACQ->FIRE transition.
  assign capture = (state_q == ST_ACQ) && enable_i && ADC_valid_i;

  // States in which a new tick cannot be serviced.
  assign busy_state = (state_q == ST_ACQ) || (state_q == ST_FIRE) ||
                      (state_q == ST_RUN);

  // The active bank only changes at a sample boundary or while idle.
  assign copy = pending_q && ((state_q == ST_IDLE) || capture);

  // Period counter: held at the reload value while disabled, and reloaded
  // whenever it expires.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (!enable_i || (cnt_q == '0)) begin
      cnt_d = sample_div_i;
    end else begin
      cnt_d = cnt_q - DIV_BITWIDTH'(1);
    end
  end

  // Scheduler FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!enable_i) state_d = ST_IDLE;
        else if (tick) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (!enable_i)   state_d = ST_IDLE;
        else if (ADC_valid_i) state_d = ST_FIRE;
      end
      ST_FIRE:  state_d = ST_RUN;
      // A running evaluation always finishes, even if the scheduler is
      // disabled meanwhile.
      ST_RUN:   if (!pid_busy_i) state_d = enable_i ? ST_ARMED : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Overrun flag and commit request: a set outranks a clear in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (tick && busy_state) overrun_d = 1'b1;
    else if (clear_overrun_i) overrun_d = 1'b0;

    pending_d = pending_q;
    if (commit_i) pending_d = 1'b1;
    else if (copy) pending_d = 1'b0;
  end

  // Control state, period counter, strobe and sample capture.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clk_en_q  <= 1'b0;
      adc_q     <= '0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_en_q  <= (state_d == ST_FIRE);
      overrun_q <= overrun_d;
      pending_q <= pending_d;
      if (capture) adc_q <= ADC_value_i;
    end
  end

  // Coefficient banks: the shadow takes software writes, and the active bank
  // copies the shadow as it stood before any write in the same cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: both banks are small register files, so they are cleared
    // explicitly. Software can then rely on zero coefficients after reset.
    if (rst_i) begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        if (coeff_wr_i && (coeff_addr_i == 3'(i))) shadow_q[i] <= coeff_data_i;
        if (copy) active_q[i] <= shadow_q[i];
      end
    end
  end

  assign clk_en_PID_o     = clk_en_q;
  assign ADC_value_o      = adc_q;
  assign b0_reg_o         = active_q[0];
  assign b1_reg_o         = active_q[1];
  assign b2_reg_o         = active_q[2];
  assign a0_reg_o         = active_q[3];
  assign a1_reg_o         = active_q[4];
  assign overrun_o        = overrun_q;
  assign commit_pending_o = pending_q;

endmodule

// File: tb/tb_pid_sample_sched.sv
// Self-checking bench for pid_sample_sched. Each expected PID strobe is queued
// with its cycle and payload when the stimulus is applied. A monitor pops and
// compares the entry when the DUT raises the strobe. A simple busy model
// holds pid_busy_i high for a set number of cycles after each strobe.
module tb_pid_sample_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [15:0] sample_div_i;
  logic [7:0]  ADC_value_i;
  logic        ADC_valid_i;
  logic        pid_busy_i;
  logic        coeff_wr_i;
  logic [2:0]  coeff_addr_i;
  logic [31:0] coeff_data_i;
  logic        commit_i;
  logic        clear_overrun_i;
  logic        clk_en_PID_o;
  logic [7:0]  ADC_value_o;
  logic [31:0] b0_reg_o, b1_reg_o, b2_reg_o, a0_reg_o, a1_reg_o;
  logic        overrun_o;
  logic        commit_pending_o;

  pid_sample_sched dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .sample_div_i    (sample_div_i),
    .ADC_value_i     (ADC_value_i),
    .ADC_valid_i     (ADC_valid_i),
    .pid_busy_i      (pid_busy_i),
    .coeff_wr_i      (coeff_wr_i),
    .coeff_addr_i    (coeff_addr_i),
    .coeff_data_i    (coeff_data_i),
    .commit_i        (commit_i),
    .clear_overrun_i (clear_overrun_i),
    .clk_en_PID_o    (clk_en_PID_o),
    .ADC_value_o     (ADC_value_o),
    .b0_reg_o        (b0_reg_o),
    .b1_reg_o        (b1_reg_o),
    .b2_reg_o        (b2_reg_o),
    .a0_reg_o        (a0_reg_o),
    .a1_reg_o        (a1_reg_o),
    .overrun_o       (overrun_o),
    .commit_pending_o(commit_pending_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle index: cycle c is the interval that follows the c-th rising edge.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [7:0]  adc;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] a1;
  } strobe_t;

  strobe_t sb_q[$];

  task automatic push_strobe(input int c, input logic [7:0] adc,
                             input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] a1);
    strobe_t e;
    e.cyc = c; e.adc = adc; e.b0 = b0; e.b1 = b1; e.a1 = a1;
    sb_q.push_back(e);
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (clk_en_PID_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 64'(cyc), 64'(-1));
      end else begin
        strobe_t e;
        e = sb_q.pop_front();
        check("strobe_cycle", 64'(cyc), 64'(e.cyc));
        check("strobe_adc", 64'(ADC_value_o), 64'(e.adc));
        check("strobe_b0", 64'(b0_reg_o), 64'(e.b0));
        check("strobe_b1", 64'(b1_reg_o), 64'(e.b1));
        check("strobe_a1", 64'(a1_reg_o), 64'(e.a1));
      end
    end
  end

  // Busy model: busy_len > 0 keeps pid_busy_i high during the RUN cycles
  // following a strobe, for busy_len-1 of them.
  int busy_len = 1;
  int busy_cnt = 0;
  initial begin
    pid_busy_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (clk_en_PID_o) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      pid_busy_i = (busy_cnt > 0);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic write_coeff(input logic [2:0] addr, input logic [31:0] data);
    coeff_wr_i = 1'b1; coeff_addr_i = addr; coeff_data_i = data;
    step();
    coeff_wr_i = 1'b0;
  endtask

  int k;

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; sample_div_i = '0; ADC_value_i = '0;
    ADC_valid_i = 1'b0; coeff_wr_i = 1'b0; coeff_addr_i = '0;
    coeff_data_i = '0; commit_i = 1'b0; clear_overrun_i = 1'b0;
    step(); step(); step();

    // Reset state
    check("rst_strobe", 64'(clk_en_PID_o), 0);
    check("rst_adc", 64'(ADC_value_o), 0);
    check("rst_coeffs", {b0_reg_o | b1_reg_o | b2_reg_o | a0_reg_o | a1_reg_o}, 0);
    check("rst_overrun", 64'(overrun_o), 0);
    check("rst_pending", 64'(commit_pending_o), 0);
    rst_i = 1'b0;
    step();

    // Basic period: divider 9, data always valid, busy 4 cycles
    sample_div_i = 16'd9; ADC_value_i = 8'h3C; ADC_valid_i = 1'b1; busy_len = 5;
    step();
    enable_i = 1'b1; k = cyc;
    push_strobe(k + 11, 8'h3C, 0, 0, 0);
    push_strobe(k + 21, 8'h3C, 0, 0, 0);
    push_strobe(k + 31, 8'h3C, 0, 0, 0);
    wait_until(k + 20);
    check("t1_overrun_mid", 64'(overrun_o), 0);
    wait_until(k + 33);
    enable_i = 1'b0;
    wait_until(k + 45);
    check("t1_strobes_left", 64'(sb_q.size()), 0);
    check("t1_overrun_end", 64'(overrun_o), 0);

    // Overrun: divider 3, busy 10 cycles, clear racing a dropped tick
    sample_div_i = 16'd3; ADC_value_i = 8'h5A; busy_len = 11;
    step();
    enable_i = 1'b1; k = cyc;
    push_strobe(k + 5, 8'h5A, 0, 0, 0);
    push_strobe(k + 21, 8'h5A, 0, 0, 0);
    wait_until(k + 7);
    check("t2_overrun_before", 64'(overrun_o), 0);
    wait_until(k + 8);
    check("t2_overrun_set", 64'(overrun_o), 1);
    wait_until(k + 11);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    check("t2_set_beats_clear", 64'(overrun_o), 1);
    wait_until(k + 13);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    check("t2_clear", 64'(overrun_o), 0);
    wait_until(k + 16);
    check("t2_overrun_reset", 64'(overrun_o), 1);
    wait_until(k + 24);
    enable_i = 1'b0;
    wait_until(k + 35);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    check("t2_overrun_cleared", 64'(overrun_o), 0);
    check("t2_strobes_left", 64'(sb_q.size()), 0);

    // ADC wait: valid held low for 5 cycles of ACQ
    sample_div_i = 16'd9; ADC_valid_i = 1'b0; ADC_value_i = 8'h00; busy_len = 2;
    step();
    enable_i = 1'b1; k = cyc;
    push_strobe(k + 16, 8'hA5, 0, 0, 0);
    wait_until(k + 14);
    check("t3_adc_held", 64'(ADC_value_o), 64'(8'h5A));
    wait_until(k + 15);
    ADC_valid_i = 1'b1; ADC_value_i = 8'hA5;
    step();
    ADC_valid_i = 1'b0; ADC_value_i = 8'h00; enable_i = 1'b0;
    step();
    check("t3_adc_latched", 64'(ADC_value_o), 64'(8'hA5));
    wait_until(k + 25);
    check("t3_overrun", 64'(overrun_o), 0);
    check("t3_strobes_left", 64'(sb_q.size()), 0);

    // Atomic commit, then disable in RUN with a pending commit
    sample_div_i = 16'd9; ADC_valid_i = 1'b1; ADC_value_i = 8'h11; busy_len = 5;
    step();
    enable_i = 1'b1; k = cyc;
    push_strobe(k + 11, 8'h11, 0, 0, 0);
    push_strobe(k + 21, 8'h11, 32'h0000_1000, 0, 32'hFFFF_F000);
    wait_until(k + 12);
    write_coeff(3'd0, 32'h0000_1000);
    write_coeff(3'd4, 32'hFFFF_F000);
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    check("t4_pending_set", 64'(commit_pending_o), 1);
    check("t4_b0_held_run", 64'(b0_reg_o), 0);
    wait_until(k + 19);
    check("t4_a1_held_armed", 64'(a1_reg_o), 0);
    wait_until(k + 20);
    write_coeff(3'd1, 32'hDEAD_BEEF);
    check("t4_pending_drop", 64'(commit_pending_o), 0);
    enable_i = 1'b0;
    step();
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    step();
    check("t4_b1_held_run", 64'(b1_reg_o), 0);
    check("t4_pending_run", 64'(commit_pending_o), 1);
    wait_until(k + 28);
    check("t4_b1_idle_copy", 64'(b1_reg_o), 64'(32'hDEAD_BEEF));
    check("t4_pending_idle", 64'(commit_pending_o), 0);
    wait_until(k + 29);
    commit_i = 1'b1;
    step();
    step();
    commit_i = 1'b0;
    check("t4_commit_vs_copy", 64'(commit_pending_o), 1);
    step();
    check("t4_pending_final", 64'(commit_pending_o), 0);
    check("t4_strobes_left", 64'(sb_q.size()), 0);

    // Disable in ACQ, then divider 0 (tick every cycle)
    sample_div_i = 16'd4; ADC_valid_i = 1'b0; busy_len = 1;
    step();
    enable_i = 1'b1; k = cyc;
    wait_until(k + 6);
    enable_i = 1'b0;
    wait_until(k + 8);
    sample_div_i = 16'd0;
    wait_until(k + 10);
    ADC_valid_i = 1'b1; ADC_value_i = 8'h77; enable_i = 1'b1; k = cyc;
    push_strobe(k + 3, 8'h77, 32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_F000);
    push_strobe(k + 7, 8'h77, 32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_F000);
    wait_until(k + 3);
    check("t5_div0_overrun", 64'(overrun_o), 1);
    wait_until(k + 8);
    enable_i = 1'b0;
    wait_until(k + 14);
    check("t5_strobes_left", 64'(sb_q.size()), 0);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;

    // Reserved addresses leave every coefficient alone
    write_coeff(3'd2, 32'h0000_0022);
    write_coeff(3'd3, 32'h0000_0033);
    write_coeff(3'd5, 32'h5555_5555);
    write_coeff(3'd6, 32'h6666_6666);
    write_coeff(3'd7, 32'h7777_7777);
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    step(); step();
    check("t6_b0", 64'(b0_reg_o), 64'(32'h0000_1000));
    check("t6_b1", 64'(b1_reg_o), 64'(32'hDEAD_BEEF));
    check("t6_b2", 64'(b2_reg_o), 64'(32'h0000_0022));
    check("t6_a0", 64'(a0_reg_o), 64'(32'h0000_0033));
    check("t6_a1", 64'(a1_reg_o), 64'(32'hFFFF_F000));

    // Reset during RUN
    sample_div_i = 16'd4; ADC_value_i = 8'hC3; ADC_valid_i = 1'b1; busy_len = 30;
    step();
    enable_i = 1'b1; k = cyc;
    push_strobe(k + 6, 8'hC3, 32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_F000);
    wait_until(k + 11);
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
    check("t7_overrun_pre", 64'(overrun_o), 1);
    check("t7_pending_pre", 64'(commit_pending_o), 1);
    wait_until(k + 13);
    rst_i = 1'b1; enable_i = 1'b0;
    step();
    rst_i = 1'b0;
    check("t7_rst_strobe", 64'(clk_en_PID_o), 0);
    check("t7_rst_adc", 64'(ADC_value_o), 0);
    check("t7_rst_b0", 64'(b0_reg_o), 0);
    check("t7_rst_b1", 64'(b1_reg_o), 0);
    check("t7_rst_b2", 64'(b2_reg_o), 0);
    check("t7_rst_a0", 64'(a0_reg_o), 0);
    check("t7_rst_a1", 64'(a1_reg_o), 0);
    check("t7_rst_overrun", 64'(overrun_o), 0);
    check("t7_rst_pending", 64'(commit_pending_o), 0);
    wait_until(k + 24);
    check("t7_strobes_left", 64'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
